// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, address constants and types for the 32x32 register file.
//   DATA_W    register width (32)
//   ADDR_W    register address width (5)
//   NUM_REGS  number of architectural registers (32)
//   ZERO_REG  hard-wired zero register address
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/mux32_5.sv
// mux32_5: 32-input, 32-bit wide selector.
//   data_i  32 packed 32-bit inputs, index 0 in the low word
//   sel_i   5-bit select
//   data_o  selected word
module mux32_5 (
  input  logic [31:0][31:0] data_i,
  input  logic [4:0]        sel_i,
  output logic [31:0]       data_o
);

  always_comb begin
    data_o = data_i[sel_i];
  end

endmodule

// File: rtl/regfile_dec5_32.sv
// regfile_dec5_32: 5-to-32 one-hot decoder with enable.
//   en_i      decode enable; output is all zeros when low
//   addr_i    register address
//   onehot_o  one-hot strobe; bit 0 is never set, so r0 cannot be targeted
module regfile_dec5_32
  import regfile_pkg::*;
(
  input  logic                en_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i && (addr_i != ZERO_REG)) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_32x32.sv
// regfile_32x32: 32 x 32-bit MIPS register file with two combinational read ports,
// one synchronous write port and a per-register busy scoreboard for RAW stalls.
//   clk, reset                   clock, synchronous active-high reset
//   RegWrite/WriteRegister/WriteData   write port (writeback, also clears busy)
//   ReadRegister1/2, ReadData1/2 combinational read ports
//   reserve_en/reserve_reg       issue-time reservation of a destination register
//   busy1/busy2                  busy flag of the addressed read registers
//   busy_vec                     registered scoreboard vector
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the
// read ports (and report busy=0 for a register being written this cycle).
module regfile_32x32
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_reg,
  output logic              busy1,
  output logic              busy2,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [NUM_REGS-1:0]             wr_strobe, rsv_strobe;
  word_t                           mux_rd1, mux_rd2;

  regfile_dec5_32 u_dec_wr (
    .en_i     (RegWrite),
    .addr_i   (WriteRegister),
    .onehot_o (wr_strobe)
  );

  regfile_dec5_32 u_dec_rsv (
    .en_i     (reserve_en),
    .addr_i   (reserve_reg),
    .onehot_o (rsv_strobe)
  );

  // Strobe bit 0 is never set, so regs_q[0] and busy_q[0] hold their reset value of 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_strobe[i]) begin
          regs_q[i] <= WriteData;
        end
      end
    end
  end

  // Reserve is OR-ed in after the writeback clear: a new producer outranks an old result.
  always_comb begin
    busy_d = (busy_q & ~wr_strobe) | rsv_strobe;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  mux32_5 u_mux_rd1 (
    .data_i (regs_q),
    .sel_i  (ReadRegister1),
    .data_o (mux_rd1)
  );

  mux32_5 u_mux_rd2 (
    .data_i (regs_q),
    .sel_i  (ReadRegister2),
    .data_o (mux_rd2)
  );

`ifdef REGFILE_BYPASS_EN
  logic hit1, hit2;

  // wr_strobe already excludes r0 and requires RegWrite.
  assign hit1 = wr_strobe[ReadRegister1];
  assign hit2 = wr_strobe[ReadRegister2];

  always_comb begin
    ReadData1 = hit1 ? WriteData : mux_rd1;
    ReadData2 = hit2 ? WriteData : mux_rd2;
    busy1     = hit1 ? 1'b0 : busy_q[ReadRegister1];
    busy2     = hit2 ? 1'b0 : busy_q[ReadRegister2];
  end
`else
  always_comb begin
    ReadData1 = mux_rd1;
    ReadData2 = mux_rd2;
    busy1     = busy_q[ReadRegister1];
    busy2     = busy_q[ReadRegister2];
  end
`endif

endmodule

// File: doc/regfile_32x32.md
Name: regfile_32x32

Overview:
- 32-entry x 32-bit MIPS general-purpose register file with two combinational read ports and one synchronous write port.
- Sits directly upstream of the decode-stage operand selection; its outputs feed the ALU operand path.
- Includes a per-register busy scoreboard. Issue logic reserves a destination register; writeback clears it. The decode stage uses the busy flags to stall on RAW hazards.

Parameters:
- DATA_W, 32, register width. Fixed at 32 in this revision; the read muxes are 32-bit.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W = 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  write address.
- WriteData  input  32  write data.
- ReadRegister1  input  5  read port 1 address.
- ReadRegister2  input  5  read port 2 address.
- ReadData1  output  32  read port 1 data, combinational.
- ReadData2  output  32  read port 2 data, combinational.
- reserve_en  input  1  mark a register as having a pending producer.
- reserve_reg  input  5  register to reserve.
- busy1  output  1  busy flag of ReadRegister1, combinational.
- busy2  output  1  busy flag of ReadRegister2, combinational.
- busy_vec  output  32  full scoreboard vector, registered.

Behaviour:
- One clock. Reset is synchronous and active-high (clk, reset).
- Reset:
  - At a posedge with reset=1, all 32 registers clear to 0 and busy_vec clears to 0.
  - Reset has priority over any simultaneous write or reserve.
  - Outputs after reset: ReadData1/2 = 0, busy1/2 = 0, busy_vec = 0.
- Write:
  - At a posedge with RegWrite=1 and WriteRegister!=0, reg[WriteRegister] <= WriteData.
  - Writes to register 0 are discarded; reg[0] always reads 0.
  - Write latency is 1 cycle; the new value is visible on the read ports after the edge.
- Read:
  - Purely combinational: ReadDataN = reg[ReadRegisterN].
  - A same-cycle read of the address being written returns the OLD value (default build).
- Scoreboard:
  - At a posedge with reserve_en=1 and reserve_reg!=0, busy_vec[reserve_reg] <= 1.
  - At a posedge with RegWrite=1 and WriteRegister!=0, busy_vec[WriteRegister] <= 0.
  - Write and reserve to the same register in the same cycle: reserve wins and the bit stays 1 (the newer producer is outstanding).
  - Write and reserve to different registers: both take effect.
  - Reserving an already-busy register keeps it at 1.
  - A write to a non-busy register is legal and leaves the bit at 0.
  - Register 0 is never busy; busy_vec[0] is constant 0.
- busyN = busy_vec[ReadRegisterN].
- Register 0 reads 0 and reports busy=0 regardless of any reserve or write.
- No X propagation: every register has a reset value.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Write-through forwarding. If RegWrite=1, WriteRegister!=0 and WriteRegister==ReadRegisterN in the same cycle, ReadDataN = WriteData.
  - busyN reads 0 in that same cycle.
  - A simultaneous reserve to the same register still sets the bit for the next cycle.
- Not defined: reads return the stored value and busy reflects busy_vec only.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS, ZERO_REG = 5'd0.
  - typedef word_t (logic [31:0]) and reg_addr_t (logic [4:0]).
- Sub-module regfile_dec5_32: 5-to-32 one-hot decoder with enable, output forced 0 when addr==0. Instanced twice, once for the write strobes and once for the reserve strobes.
- Read selection reuses the team's existing 32:1 32-bit mux (mux32_5), instanced once per read port. The bypass mux sits after it.

Test Plan:
- Reset then read all 32 addresses -> every ReadData = 0x00000000; busy_vec = 0.
- Write 0xDEADBEEF to r5, then read r5 on port 1 and r0 on port 2 next cycle -> ReadData1 = 0xDEADBEEF, ReadData2 = 0.
- Write 0x12345678 to r0 -> r0 still reads 0; busy_vec[0] = 0.
- Reserve r7; next cycle read r7 -> busy1 = 1. Write r7 = 0xA5A5A5A5 -> next cycle busy1 = 0, ReadData1 = 0xA5A5A5A5.
- Same-cycle reserve r9 and write r9 = 0x1 -> after the edge busy_vec[9] = 1, r9 = 0x1. Same-cycle read returns the old value (default) or 0x1 with busy = 0 (REGFILE_BYPASS_EN).
- Write r3 = 0xFFFFFFFF and reserve r4, then reset with RegWrite=1 to r3 asserted -> r3 = 0 and busy_vec = 0 after the edge.
